btn_debounce: RTL and testbench

- Input conditioning stage that sits directly upstream of the whack-a-mole game core inside tt_um_whack_a_mole.
- Takes the raw, asynchronous player buttons from ui_in, synchronises and debounces each one independently.
- Outputs a clean level plus single-cycle press and release pulses per button; the game FSM consumes only these pulses to register a "whack".

---
 rtl/btn_debounce_if.sv | 39 +++
 rtl/btn_debounce.sv | 94 +++++++++
 tb/tb_btn_debounce.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/btn_debounce_if.sv
// -----------------------------------------------------------------------------
// btn_debounce_if
// Groups the button-conditioning signals between the tile wrapper / game core
// (master side) and the debouncer (slave side).
//   ena         : enable from the tile wrapper, low freezes debouncing
//   btn_raw     : raw asynchronous active-high buttons
//   btn_level   : debounced stable level per button
//   btn_press   : one-cycle pulse per accepted 0->1 transition
//   btn_release : one-cycle pulse per accepted 1->0 transition
//   any_press   : OR of btn_press, same cycle
// -----------------------------------------------------------------------------
interface btn_debounce_if #(
    parameter int N_BTN = 4
);
    logic             ena;
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic             any_press;

    modport master (
        output ena,
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  any_press
    );

    modport slave (
        input  ena,
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output any_press
    );
endinterface

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Synchronises and debounces N_BTN independent raw buttons. Each channel
// accepts a new level only after the synchronised input has differed from the
// stable level for DB_CYCLES consecutive enabled clocks, then emits a single
// registered press or release pulse.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset, clears every flop
//   bus   : btn_debounce_if slave modport (ena, btn_raw in; level/pulses out)
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int N_BTN     = 4,
    parameter int DB_CYCLES = 20000
) (
    input  logic          clk,
    input  logic          rst_n,
    btn_debounce_if.slave bus
);
    localparam int               CNT_W    = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [N_BTN-1:0]            sync1_r;
    logic [N_BTN-1:0]            sync2_r;
    logic [N_BTN-1:0]            stable_r;
    logic [N_BTN-1:0][CNT_W-1:0] cnt_r;
    logic [N_BTN-1:0]            press_r;
    logic [N_BTN-1:0]            release_r;
    logic                        any_press_r;

    logic [N_BTN-1:0]            stable_nxt_s;
    logic [N_BTN-1:0][CNT_W-1:0] cnt_nxt_s;
    logic [N_BTN-1:0]            press_nxt_s;
    logic [N_BTN-1:0]            release_nxt_s;

    // Two-flop synchroniser; runs independently of ena so the sampled view
    // of the buttons is always current when debouncing resumes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= bus.btn_raw;
            sync2_r <= sync1_r;
        end
    end

    // Per-channel debounce decision: count consecutive mismatches, accept on
    // the DB_CYCLES-th one; any matching cycle or disabled cycle restarts.
    always_comb begin
        stable_nxt_s  = stable_r;
        cnt_nxt_s     = cnt_r;
        press_nxt_s   = '0;
        release_nxt_s = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (!bus.ena) begin
                cnt_nxt_s[i] = CNT_ZERO;
            end else if (sync2_r[i] == stable_r[i]) begin
                cnt_nxt_s[i] = CNT_ZERO;
            end else if (cnt_r[i] == CNT_LAST) begin
                stable_nxt_s[i]  = sync2_r[i];
                cnt_nxt_s[i]     = CNT_ZERO;
                press_nxt_s[i]   = sync2_r[i];
                release_nxt_s[i] = ~sync2_r[i];
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end
        end
    end

    // Debounce state and registered pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_r    <= '0;
            cnt_r       <= '0;
            press_r     <= '0;
            release_r   <= '0;
            any_press_r <= 1'b0;
        end else begin
            stable_r    <= stable_nxt_s;
            cnt_r       <= cnt_nxt_s;
            press_r     <= press_nxt_s;
            release_r   <= release_nxt_s;
            any_press_r <= |press_nxt_s;
        end
    end

    assign bus.btn_level   = stable_r;
    assign bus.btn_press   = press_r;
    assign bus.btn_release = release_r;
    assign bus.any_press   = any_press_r;
endmodule

// File: tb/tb_btn_debounce.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce
// Self-checking bench for btn_debounce with DB_CYCLES=4. A window-based
// reference model decides acceptances from the history of raw inputs and ena:
// a channel accepts at edge k when the last DB edges were all enabled, all saw
// the synchronised input differ from the stable level, and no acceptance fell
// inside that window.
// -----------------------------------------------------------------------------
module tb_btn_debounce;
    localparam int N    = 4;
    localparam int DB   = 4;
    localparam int MAXE = 4096;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    btn_debounce_if #(.N_BTN(N)) bus ();

    btn_debounce #(.N_BTN(N), .DB_CYCLES(DB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic [N-1:0] raw_at [MAXE];
    logic         ena_at [MAXE];
    int           edge_n;
    int           last_acc [N];
    logic [N-1:0] m_stable;
    logic [N-1:0] m_press;
    logic [N-1:0] m_release;
    int           press_seen [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp_v, edge_n);
        end
    endtask

    function automatic logic [N-1:0] sync_at(input int e);
        if (e >= 3) return raw_at[e-2];
        else return '0;
    endfunction

    task automatic model_reset();
        edge_n    = 0;
        m_stable  = '0;
        m_press   = '0;
        m_release = '0;
        for (int c = 0; c < N; c++) last_acc[c] = 0;
    endtask

    task automatic model_edge();
        logic [N-1:0] s;
        bit ok;
        m_press   = '0;
        m_release = '0;
        for (int c = 0; c < N; c++) begin
            ok = 1'b1;
            if (edge_n < DB || last_acc[c] > edge_n - DB) ok = 1'b0;
            else begin
                for (int j = edge_n - DB + 1; j <= edge_n; j++) begin
                    s = sync_at(j);
                    if (!ena_at[j] || s[c] == m_stable[c]) ok = 1'b0;
                end
            end
            if (ok) begin
                m_stable[c] = ~m_stable[c];
                last_acc[c] = edge_n;
                if (m_stable[c]) m_press[c] = 1'b1;
                else m_release[c] = 1'b1;
            end
        end
    endtask

    // One clock: drive at the negedge, model the posedge, compare #1 later.
    task automatic step(input logic [N-1:0] raw, input logic en);
        bus.btn_raw = raw;
        bus.ena     = en;
        @(posedge clk);
        if (edge_n >= MAXE - 1) begin
            $display("FAIL model_overflow: got %0d expected below %0d", edge_n, MAXE - 1);
            $fatal(1);
        end
        edge_n++;
        raw_at[edge_n] = raw;
        ena_at[edge_n] = en;
        model_edge();
        #1;
        chk("level",   32'(bus.btn_level),   32'(m_stable));
        chk("press",   32'(bus.btn_press),   32'(m_press));
        chk("release", 32'(bus.btn_release), 32'(m_release));
        chk("any",     32'(bus.any_press),   32'(|m_press));
        for (int c = 0; c < N; c++) press_seen[c] += int'(bus.btn_press[c]);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_level"},   32'(bus.btn_level),   32'h0);
        chk({tag, "_press"},   32'(bus.btn_press),   32'h0);
        chk({tag, "_release"}, 32'(bus.btn_release), 32'h0);
        chk({tag, "_any"},     32'(bus.any_press),   32'h0);
    endtask

    // Assert reset at a negedge, hold it n cycles with raw applied, release.
    task automatic do_reset(input int n, input logic [N-1:0] raw);
        rst_n       = 1'b0;
        bus.btn_raw = raw;
        #1;
        check_zero("rst_imm");
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_zero("rst_hold");
            @(negedge clk);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int p0;
        logic [N-1:0] r;
        logic e;
        n_total = 0;
        n_bad   = 0;
        for (int c = 0; c < N; c++) press_seen[c] = 0;
        rst_n       = 1'b0;
        bus.ena     = 1'b1;
        bus.btn_raw = '0;
        model_reset();
        @(negedge clk);

        // Reset with all buttons held: fresh press 6 edges after release.
        do_reset(5, 4'hF);
        for (int i = 1; i <= 5; i++) step(4'hF, 1'b1);
        chk("rst_no_early_press", 32'(bus.btn_press), 32'h0);
        step(4'hF, 1'b1);
        chk("rst_press6", 32'(bus.btn_press), 32'hF);
        chk("rst_any6", 32'(bus.any_press), 32'h1);
        step(4'hF, 1'b1);
        chk("rst_press7", 32'(bus.btn_press), 32'h0);
        chk("rst_level7", 32'(bus.btn_level), 32'hF);
        for (int i = 0; i < 8; i++) step(4'h0, 1'b1);
        chk("all_released", 32'(bus.btn_level), 32'h0);

        // Clean press and release on bit0.
        for (int i = 1; i <= 6; i++) step(4'h1, 1'b1);
        chk("b0_press6", 32'(bus.btn_press), 32'h1);
        step(4'h1, 1'b1);
        chk("b0_press_one_cycle", 32'(bus.btn_press), 32'h0);
        p0 = press_seen[0];
        for (int i = 1; i <= 6; i++) step(4'h0, 1'b1);
        chk("b0_release6", 32'(bus.btn_release), 32'h1);
        chk("b0_no_press_in_release", 32'(press_seen[0] - p0), 32'h0);
        step(4'h0, 1'b1);
        chk("b0_release_one_cycle", 32'(bus.btn_release), 32'h0);

        // Glitch on bit1: 3 cycles high is rejected.
        p0 = press_seen[1];
        for (int i = 0; i < 3; i++) step(4'h2, 1'b1);
        for (int i = 0; i < 8; i++) step(4'h0, 1'b1);
        chk("glitch_no_press", 32'(press_seen[1] - p0), 32'h0);
        chk("glitch_level", 32'(bus.btn_level), 32'h0);

        // Bounce on bit2: 1,1,0 then held high -> exactly one press.
        p0 = press_seen[2];
        step(4'h4, 1'b1);
        step(4'h4, 1'b1);
        step(4'h0, 1'b1);
        for (int i = 1; i <= 6; i++) step(4'h4, 1'b1);
        chk("bounce_press6", 32'(bus.btn_press), 32'h4);
        for (int i = 0; i < 6; i++) step(4'h4, 1'b1);
        chk("bounce_one_pulse", 32'(press_seen[2] - p0), 32'h1);

        // ena gating on bit3: ena low for edges 3..10, press on edge 14.
        p0 = press_seen[3];
        for (int i = 1; i <= 13; i++) step(4'hC, (i >= 3 && i <= 10) ? 1'b0 : 1'b1);
        chk("ena_no_early_press", 32'(press_seen[3] - p0), 32'h0);
        step(4'hC, 1'b1);
        chk("ena_press14", 32'(bus.btn_press), 32'h8);

        // Simultaneous press of bits 0 and 3.
        for (int i = 0; i < 8; i++) step(4'h0, 1'b1);
        for (int i = 1; i <= 6; i++) step(4'h9, 1'b1);
        chk("simul_press", 32'(bus.btn_press), 32'h9);
        chk("simul_any", 32'(bus.any_press), 32'h1);
        step(4'h9, 1'b1);
        chk("simul_any_once", 32'(bus.any_press), 32'h0);

        // Reset mid-operation with bit0 held: fresh press after release.
        do_reset(3, 4'h1);
        for (int i = 1; i <= 6; i++) step(4'h1, 1'b1);
        chk("midrst_press6", 32'(bus.btn_press), 32'h1);

        // Randomised phase against the model.
        r = 4'h0;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 5) == 0) r[c] = ~r[c];
            e = ($urandom_range(0, 11) != 0);
            step(r, e);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
